// File: rtl/stage2_cnn_kernel_chacc_pkg.sv
// Shared defaults, derived widths and helpers for the stage-2 multi-channel kernel MAC.
// The optional CNN_KERNEL_SAT_EN build uses sat_signed() for the output clip.
package stage2_cnn_kernel_chacc_pkg;

  localparam int KX_DEF    = 5;
  localparam int KY_DEF    = 5;
  localparam int CH_IN_DEF = 3;
  localparam int IBW_DEF   = 20;
  localparam int W_BW_DEF  = 8;
  localparam int M_BW_DEF  = IBW_DEF + W_BW_DEF;
  localparam int AK_BW_DEF = M_BW_DEF + $clog2(KX_DEF * KY_DEF);

  // Working width for saturation; the full accumulator must fit in it.
  localparam int SAT_W = 128;

  // Counter width that stays legal when only one channel is accumulated.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp x to the signed obw-bit range; the result is sign-extended to SAT_W.
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input  logic signed [SAT_W-1:0] x,
    input  int                      obw,
    output logic                    clipped
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    one     = 1;
    max_v   = (one <<< (obw - 1)) - one;
    min_v   = ~max_v;
    clipped = (x > max_v) || (x < min_v);
    if (x > max_v)      return max_v;
    else if (x < min_v) return min_v;
    else                return x;
  endfunction

endpackage

// File: rtl/stage2_cnn_kernel_chacc_if.sv
// Beat-in / partial-sum-out handshake bundle for stage2_cnn_kernel_chacc.
// o_ot_sat exists only when CNN_KERNEL_SAT_EN is defined.
interface stage2_cnn_kernel_chacc_if
  import stage2_cnn_kernel_chacc_pkg::*;
#(
  parameter int KX    = KX_DEF,
  parameter int KY    = KY_DEF,
  parameter int IBW   = IBW_DEF,
  parameter int W_BW  = W_BW_DEF,
  parameter int OBW   = AK_BW_DEF + $clog2(CH_IN_DEF)
);

  logic [KX*KY*W_BW-1:0]  i_cnn_weight;
  logic [KX*KY*IBW-1:0]   i_in_fmap;
  logic                   i_in_valid;
  logic                   o_in_ready;
  logic                   o_ot_valid;
  logic                   i_ot_ready;
  logic signed [OBW-1:0]  o_ot_kernel_acc;
  logic                   o_ot_busy;
`ifdef CNN_KERNEL_SAT_EN
  logic                   o_ot_sat;

  modport master (
    output i_cnn_weight, i_in_fmap, i_in_valid, i_ot_ready,
    input  o_in_ready, o_ot_valid, o_ot_kernel_acc, o_ot_busy, o_ot_sat
  );
  modport slave (
    input  i_cnn_weight, i_in_fmap, i_in_valid, i_ot_ready,
    output o_in_ready, o_ot_valid, o_ot_kernel_acc, o_ot_busy, o_ot_sat
  );
`else
  modport master (
    output i_cnn_weight, i_in_fmap, i_in_valid, i_ot_ready,
    input  o_in_ready, o_ot_valid, o_ot_kernel_acc, o_ot_busy
  );
  modport slave (
    input  i_cnn_weight, i_in_fmap, i_in_valid, i_ot_ready,
    output o_in_ready, o_ot_valid, o_ot_kernel_acc, o_ot_busy
  );
`endif

endinterface

// File: rtl/stage2_cnn_dot_kxky.sv
// KX*KY signed dot product: S1 registers the products, S2 registers their sum.
// Both stages move only on ce; the valid bits travel alongside the data.
module stage2_cnn_dot_kxky
  import stage2_cnn_kernel_chacc_pkg::*;
#(
  parameter  int KX    = KX_DEF,
  parameter  int KY    = KY_DEF,
  parameter  int IBW   = IBW_DEF,
  parameter  int W_BW  = W_BW_DEF,
  localparam int N     = KX * KY,
  localparam int M_BW  = IBW + W_BW,
  localparam int AK_BW = M_BW + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic [N*IBW-1:0]        fmap,
  input  logic [N*W_BW-1:0]       weight,
  output logic                    out_valid,
  output logic signed [AK_BW-1:0] sum,
  output logic                    pipe_busy
);

  logic signed [M_BW-1:0]  prod_next [N];
  logic signed [M_BW-1:0]  prod_reg  [N];
  logic signed [AK_BW-1:0] prod_ext  [N];
  logic signed [AK_BW-1:0] sum_next;
  logic signed [AK_BW-1:0] sum_reg;
  logic                    v1_reg;
  logic                    v2_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mul
      logic signed [IBW-1:0]  f_el;
      logic signed [W_BW-1:0] w_el;
      assign f_el          = fmap[gi*IBW +: IBW];
      assign w_el          = weight[gi*W_BW +: W_BW];
      // Operands widened first so the product is the exact signed result.
      assign prod_next[gi] = M_BW'(f_el) * M_BW'(w_el);
      assign prod_ext[gi]  = AK_BW'(prod_reg[gi]);
    end
  endgenerate

  always_comb begin
    sum_next = '0;
    for (int k = 0; k < N; k++) begin
      sum_next = sum_next + prod_ext[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg  <= 1'b0;
      v2_reg  <= 1'b0;
      sum_reg <= '0;
      for (int k = 0; k < N; k++) begin
        prod_reg[k] <= '0;
      end
    end else if (ce) begin
      v1_reg <= in_valid;
      v2_reg <= v1_reg;
      if (in_valid) begin
        for (int k = 0; k < N; k++) begin
          prod_reg[k] <= prod_next[k];
        end
      end
      if (v1_reg) begin
        sum_reg <= sum_next;
      end
    end
  end

  assign out_valid = v2_reg;
  assign sum       = sum_reg;
  assign pipe_busy = v1_reg || v2_reg;

endmodule

// File: rtl/stage2_cnn_kernel_chacc.sv
// Stage-2 kernel MAC with channel accumulation: CH_IN dot-product beats form one output.
// Define CNN_KERNEL_SAT_EN to saturate (instead of truncate) into OBW and add o_ot_sat.
module stage2_cnn_kernel_chacc
  import stage2_cnn_kernel_chacc_pkg::*;
#(
  parameter int KX    = KX_DEF,
  parameter int KY    = KY_DEF,
  parameter int CH_IN = CH_IN_DEF,
  parameter int IBW   = IBW_DEF,
  parameter int W_BW  = W_BW_DEF,
  parameter int OBW   = IBW + W_BW + $clog2(KX * KY) + $clog2(CH_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  stage2_cnn_kernel_chacc_if.slave bus
);

  localparam int AK_BW  = IBW + W_BW + $clog2(KX * KY);
  localparam int ACC_BW = AK_BW + $clog2(CH_IN);
  localparam int CNT_BW = cnt_width(CH_IN);
  localparam logic [CNT_BW-1:0] LAST_CH = CNT_BW'(CH_IN - 1);

  logic                     ce;
  logic                     v2;
  logic                     dot_busy;
  logic                     last_ch;
  logic signed [AK_BW-1:0]  sum;
  logic [CNT_BW-1:0]        ch_cnt_reg;
  logic [CNT_BW-1:0]        ch_cnt_next;
  logic signed [ACC_BW-1:0] acc_reg;
  logic signed [ACC_BW-1:0] acc_next;
  logic                     ot_valid_reg;
  logic signed [OBW-1:0]    ot_acc_reg;
  logic signed [OBW-1:0]    ot_acc_next;

  // Whole pipeline stalls together while a result waits downstream.
  assign ce             = !ot_valid_reg || bus.i_ot_ready;
  assign bus.o_in_ready = ce;

  stage2_cnn_dot_kxky #(
    .KX   (KX),
    .KY   (KY),
    .IBW  (IBW),
    .W_BW (W_BW)
  ) u_dot (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (bus.i_in_valid),
    .fmap      (bus.i_in_fmap),
    .weight    (bus.i_cnn_weight),
    .out_valid (v2),
    .sum       (sum),
    .pipe_busy (dot_busy)
  );

  assign last_ch = (ch_cnt_reg == LAST_CH);

  always_comb begin
    ch_cnt_next = last_ch ? '0 : ch_cnt_reg + CNT_BW'(1);
    acc_next    = (ch_cnt_reg == '0) ? ACC_BW'(sum) : acc_reg + ACC_BW'(sum);
  end

`ifdef CNN_KERNEL_SAT_EN
  logic                    sat_clip;
  logic                    ot_sat_reg;
  logic signed [SAT_W-1:0] sat_full;
  logic                    sat_unused;

  always_comb begin
    sat_clip = 1'b0;
    sat_full = sat_signed(SAT_W'(acc_next), OBW, sat_clip);
  end
  assign ot_acc_next = sat_full[OBW-1:0];
  assign sat_unused  = ^sat_full[SAT_W-1:OBW];

  always_ff @(posedge clk) begin
    if (reset) begin
      ot_sat_reg <= 1'b0;
    end else if (ce) begin
      ot_sat_reg <= v2 && last_ch && sat_clip;
    end
  end
  assign bus.o_ot_sat = ot_sat_reg;
`else
  assign ot_acc_next = OBW'(acc_next);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_cnt_reg   <= '0;
      acc_reg      <= '0;
      ot_valid_reg <= 1'b0;
      ot_acc_reg   <= '0;
    end else if (ce) begin
      if (v2) begin
        acc_reg    <= acc_next;
        ch_cnt_reg <= ch_cnt_next;
      end
      // A new final result replaces one being accepted in the same cycle.
      if (v2 && last_ch) begin
        ot_valid_reg <= 1'b1;
        ot_acc_reg   <= ot_acc_next;
      end else begin
        ot_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.o_ot_valid      = ot_valid_reg;
  assign bus.o_ot_kernel_acc = ot_acc_reg;
  assign bus.o_ot_busy       = (ch_cnt_reg != '0) || dot_busy || ot_valid_reg;

endmodule
